systolic_sequencer: RTL



---
 rtl/tpu_ctrl_pkg.sv | 23 ++
 rtl/systolic_sequencer_sat_counter.sv | 29 ++
 rtl/systolic_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared control definitions for the systolic tile sequencer:
// FSM state encoding, stream length helper and default drain length.
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } seq_state_t;

    localparam int SEQ_N_DEFAULT = 4;

    // A systolic array of dimension N drains in N cycles.
    localparam int DRAIN_LEN = SEQ_N_DEFAULT;

    // A skewed N-wide wavefront needs 2N-1 shifts to cross the array.
    function automatic int stream_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear, used for the optional
// sequencer performance counters (built only with SEQ_PERF_CNT_EN).
`ifdef SEQ_PERF_CNT_EN
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/systolic_sequencer.sv
// Control FSM sequencing tile fetch, skewed streaming and drain of a systolic
// array. Optional perf counters are enabled with the SEQ_PERF_CNT_EN macro.
module systolic_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int N          = SEQ_N_DEFAULT,
    parameter int TILE_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [TILE_CNT_W-1:0] cmd_tiles,
    output logic                  tile_req,
    input  logic                  tile_valid,
    output logic                  arr_load,
    output logic                  arr_step,
    output logic                  pe_clear,
    output logic                  pe_acc_en,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_busy_cyc,
    output logic [31:0]           perf_stall_cyc
`endif
);

    localparam int STREAM_LEN = stream_len(N);
    localparam int STEP_W     = $clog2(2 * N - 1) + 1;

    localparam logic [STEP_W-1:0] STEP_STREAM_LAST = STEP_W'(STREAM_LEN - 1);
    // Drain length tracks the instance's N rather than the package default.
    localparam logic [STEP_W-1:0] STEP_DRAIN_LAST  = STEP_W'(N - 1);

    seq_state_t            r_state, w_state_nxt;
    logic [TILE_CNT_W-1:0] r_rem, w_rem_nxt;
    logic [STEP_W-1:0]     r_step, w_step_nxt;
    logic                  r_result_valid, w_result_valid_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_rem          <= '0;
            r_step         <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rem          <= w_rem_nxt;
            r_step         <= w_step_nxt;
            r_result_valid <= w_result_valid_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt        = r_state;
        w_rem_nxt          = r_rem;
        w_step_nxt         = r_step;
        w_result_valid_nxt = r_result_valid;
        cmd_ready          = 1'b0;
        tile_req           = 1'b0;
        arr_load           = 1'b0;
        arr_step           = 1'b0;
        pe_clear           = 1'b0;
        pe_acc_en          = 1'b0;
        done               = 1'b0;

        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    pe_clear           = 1'b1;
                    w_result_valid_nxt = 1'b0;
                    w_rem_nxt          = cmd_tiles;
                    w_state_nxt        = (cmd_tiles == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                tile_req = 1'b1;
                if (tile_valid) begin
                    // FETCH is only entered with r_rem != 0, so this never wraps.
                    arr_load    = 1'b1;
                    w_rem_nxt   = r_rem - 1'b1;
                    w_step_nxt  = '0;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                arr_step  = 1'b1;
                pe_acc_en = 1'b1;
                if (r_step == STEP_STREAM_LAST) begin
                    w_step_nxt  = '0;
                    w_state_nxt = (r_rem != '0) ? FETCH : DRAIN;
                end else begin
                    w_step_nxt = r_step + 1'b1;
                end
            end
            DRAIN: begin
                pe_acc_en = 1'b1;
                if (r_step == STEP_DRAIN_LAST) begin
                    w_step_nxt  = '0;
                    w_state_nxt = FINISH;
                end else begin
                    w_step_nxt = r_step + 1'b1;
                end
            end
            FINISH: begin
                done               = 1'b1;
                w_result_valid_nxt = 1'b1;
                w_state_nxt        = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy         = (r_state != IDLE);
    assign result_valid = r_result_valid;

`ifdef SEQ_PERF_CNT_EN
    logic w_accept;
    logic w_stall;

    assign w_accept = cmd_ready & cmd_valid;
    assign w_stall  = (r_state == FETCH) & ~tile_valid;

    sat_counter #(.W(32)) u_busy_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (busy),
        .i_clr   (w_accept),
        .o_cnt   (perf_busy_cyc)
    );

    sat_counter #(.W(32)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_stall),
        .i_clr   (w_accept),
        .o_cnt   (perf_stall_cyc)
    );
`endif

endmodule
